// File: rtl/mcu_spi_pkg.sv
// Shared constants and FSM state type for the MCU SPI target front end.
package mcu_spi_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] TGT_SYS = 8'd0;
    localparam logic [BYTE_W-1:0] TGT_HID = 8'd1;
    localparam logic [BYTE_W-1:0] TGT_OSD = 8'd2;
    localparam logic [BYTE_W-1:0] TGT_SDC = 8'd3;

    localparam logic [BYTE_W-1:0] MCU_SPI_IDLE_REPLY = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TGT  = 2'd1,
        DATA = 2'd2,
        SINK = 2'd3
    } mcu_spi_state_e;

endpackage

// File: rtl/mcu_spi_sync.sv
// Two-flop synchroniser with rise/fall detect taken from the synchronised history.
module mcu_spi_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout,
    output logic rise_c,
    output logic fall_c
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign dout   = sync_q;
    assign rise_c = sync_q & ~prev_q;
    assign fall_c = ~sync_q & prev_q;

endmodule

// File: rtl/mcu_spi_target.sv
// Oversampled SPI mode-0 target: first byte picks a decoder, later bytes are strobed to it.
// Optional transaction watchdog enabled with MCU_SPI_TIMEOUT_EN.
module mcu_spi_target
    import mcu_spi_pkg::*;
#(
    parameter int unsigned NUM_TARGETS = 4,
    parameter int unsigned TIMEOUT     = 4096
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          spi_ss_n,
    input  logic                          spi_sclk,
    input  logic                          spi_mosi,
    output logic                          spi_miso,
    output logic                          mcu_strobe,
    output logic                          mcu_start,
    output logic [BYTE_W-1:0]             mcu_data,
    output logic [NUM_TARGETS-1:0]        mcu_target_sel,
    input  logic [BYTE_W*NUM_TARGETS-1:0] mcu_reply,
    output logic                          abort
);

    if (NUM_TARGETS < 1 || NUM_TARGETS > 256 || TIMEOUT < 2) begin : g_bad_cfg
        $error("mcu_spi_target: unsupported NUM_TARGETS or TIMEOUT");
    end

    logic ss_sync, ss_rise_c, ss_fall_c;
    logic sclk_sync, sclk_rise_c, sclk_fall_c;

    // ss_n resets to "selected" so a reset released mid-transaction cannot look like a fresh select.
    mcu_spi_sync #(.RESET_VAL(1'b0)) u_ss_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .din    (spi_ss_n),
        .dout   (ss_sync),
        .rise_c (ss_rise_c),
        .fall_c (ss_fall_c)
    );

    mcu_spi_sync #(.RESET_VAL(1'b0)) u_sclk_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .din    (spi_sclk),
        .dout   (sclk_sync),
        .rise_c (sclk_rise_c),
        .fall_c (sclk_fall_c)
    );

    mcu_spi_state_e           state_q, state_d;
    logic                     armed_q, armed_d;
    logic [2:0]               bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-2:0]        rx_shift_q, rx_shift_d;
    logic                     first_q, first_d;
    logic                     strobe_q, strobe_d;
    logic                     start_q, start_d;
    logic [BYTE_W-1:0]        data_q, data_d;
    logic [NUM_TARGETS-1:0]   sel_q, sel_d;
    logic                     done_q, done_d;
    logic                     load_q, load_d;
    logic [BYTE_W-1:0]        tx_q, tx_d;
    logic                     abort_q, abort_d;
    logic                     mosi_meta_q, mosi_meta_d;
    logic                     mosi_sync_q, mosi_sync_d;

    logic [BYTE_W-1:0]        rx_byte;
    logic [BYTE_W-1:0]        reply_sel;
    logic                     id_valid;
    logic [NUM_TARGETS-1:0]   id_onehot;

`ifdef MCU_SPI_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

    assign rx_byte  = {rx_shift_q, mosi_sync_q};
    assign id_valid = 32'(rx_byte) < NUM_TARGETS;

    // Reply mux and id decode; sel_q stays zero in SINK so the reply defaults to idle.
    always_comb begin
        reply_sel = MCU_SPI_IDLE_REPLY;
        id_onehot = '0;
        for (int unsigned i = 0; i < NUM_TARGETS; i++) begin
            if (sel_q[i]) begin
                reply_sel = mcu_reply[BYTE_W*i +: BYTE_W];
            end
            id_onehot[i] = (32'(rx_byte) == i);
        end
    end

    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        first_d     = first_q;
        strobe_d    = 1'b0;
        start_d     = 1'b0;
        data_d      = data_q;
        sel_d       = sel_q;
        done_d      = 1'b0;
        load_d      = done_q;
        tx_d        = tx_q;
        abort_d     = 1'b0;
        mosi_meta_d = spi_mosi;
        mosi_sync_d = mosi_meta_q;

        if (ss_rise_c) begin
            armed_d = 1'b1;
        end

        if (ss_sync || state_q == IDLE) begin
            bit_cnt_d  = '0;
            rx_shift_d = '0;
            first_d    = 1'b0;
            sel_d      = '0;
            tx_d       = '0;
            load_d     = 1'b0;
            state_d    = (!ss_sync && ss_fall_c && armed_q) ? TGT : IDLE;
        end else begin
            if (sclk_rise_c) begin
                bit_cnt_d  = bit_cnt_q + 3'd1;
                rx_shift_d = rx_byte[BYTE_W-2:0];
                if (bit_cnt_q == 3'd7) begin
                    done_d = 1'b1;
                    case (state_q)
                        TGT: begin
                            first_d = 1'b1;
                            sel_d   = id_valid ? id_onehot : '0;
                            state_d = id_valid ? DATA : SINK;
                        end
                        DATA: begin
                            strobe_d = 1'b1;
                            start_d  = first_q;
                            data_d   = rx_byte;
                            first_d  = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end

            // The fall after the 8th rise must not shift: it is where the reloaded bit 7 appears.
            if (load_q) begin
                tx_d = reply_sel;
            end else if (sclk_fall_c && bit_cnt_q != 3'd0) begin
                tx_d = {tx_q[BYTE_W-2:0], 1'b0};
            end
        end

`ifdef MCU_SPI_TIMEOUT_EN
        to_cnt_d = '0;
        if (!ss_sync && state_q != IDLE && !sclk_rise_c && !sclk_fall_c) begin
            if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                abort_d = 1'b1;
                armed_d = 1'b0;
                state_d = IDLE;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            armed_q     <= 1'b0;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            first_q     <= 1'b0;
            strobe_q    <= 1'b0;
            start_q     <= 1'b0;
            data_q      <= '0;
            sel_q       <= '0;
            done_q      <= 1'b0;
            load_q      <= 1'b0;
            tx_q        <= '0;
            abort_q     <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            first_q     <= first_d;
            strobe_q    <= strobe_d;
            start_q     <= start_d;
            data_q      <= data_d;
            sel_q       <= sel_d;
            done_q      <= done_d;
            load_q      <= load_d;
            tx_q        <= tx_d;
            abort_q     <= abort_d;
            mosi_meta_q <= mosi_meta_d;
            mosi_sync_q <= mosi_sync_d;
        end
    end

`ifdef MCU_SPI_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

    assign spi_miso       = tx_q[BYTE_W-1];
    assign mcu_strobe     = strobe_q;
    assign mcu_start      = start_q;
    assign mcu_data       = data_q;
    assign mcu_target_sel = sel_q;
    assign abort          = abort_q;

    logic unused_sclk_level;
    assign unused_sclk_level = sclk_sync;

endmodule
